// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: segmented, pipelined WIDTH-bit adder/subtractor.
// The operands are split into STAGES = WIDTH/SEG segments. Each stage ripples
// one SEG-bit segment and registers its carry for the next stage, so the clock
// period only covers SEG-bit ripple logic.
//
// Handshake (both sides): a beat moves across a port on a rising clk edge where
// valid & ready are both high. The input side is ready whenever the output is
// not stalled (stall = out_valid & ~out_ready); while stalled every pipe
// register holds, so s/c_out/out_valid stay stable until the consumer takes
// them. A bubble at the output never stalls; it is simply overwritten.
//
// Optional build macro PIPELINED_ADDER_FLAGS_EN adds the registered status
// outputs ovf (signed overflow), zero (s == 0) and neg (s MSB), aligned with s.
module pipelined_adder_sub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef PIPELINED_ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int STAGES = (WIDTH / SEG < 1) ? 1 : WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  logic             stall;
  logic [WIDTH-1:0] b_eff;

  // Subtraction is a + ~b + 1; the forced carry-in is applied in stage 0.
  assign b_eff    = sub ? ~b : b;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage k adds segment k. Its registers hold the result bits finished so
  // far (k+1 segments), its segment carry, its valid bit and, except in the
  // last stage, the operand segments still waiting to be added.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE_W = (k + 1) * SEG;

    logic [SEG-1:0]    a_seg;
    logic [SEG-1:0]    b_seg;
    logic              cin;
    logic              v_in;
    logic [SEG:0]      seg_sum;
    logic [DONE_W-1:0] sum_d;
    logic [DONE_W-1:0] sum_q;
    logic              cy_q;
    logic              vld_q;

    if (k == 0) begin : g_src
      assign a_seg = a[SEG-1:0];
      assign b_seg = b_eff[SEG-1:0];
      assign cin   = sub | c_in;
      assign v_in  = in_valid;
      assign sum_d = seg_sum[SEG-1:0];
    end else begin : g_src
      assign a_seg = g_stage[k-1].g_fwd.a_rest_q[SEG-1:0];
      assign b_seg = g_stage[k-1].g_fwd.b_rest_q[SEG-1:0];
      assign cin   = g_stage[k-1].cy_q;
      assign v_in  = g_stage[k-1].vld_q;
      assign sum_d = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
    end

    assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, cin};

    // Valid always advances unless stalled; data only loads for a real beat,
    // so bubbles leave the last result (or the reset zeros) in place.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        sum_q <= '0;
        cy_q  <= 1'b0;
      end else if (!stall) begin
        vld_q <= v_in;
        if (v_in) begin
          sum_q <= sum_d;
          cy_q  <= seg_sum[SEG];
        end
      end
    end

    if (k < LAST) begin : g_fwd
      localparam int REST_W = WIDTH - DONE_W;

      logic [REST_W-1:0] a_rest_d;
      logic [REST_W-1:0] b_rest_d;
      logic [REST_W-1:0] a_rest_q;
      logic [REST_W-1:0] b_rest_q;

      if (k == 0) begin : g_rest_src
        assign a_rest_d = a[WIDTH-1:SEG];
        assign b_rest_d = b_eff[WIDTH-1:SEG];
      end else begin : g_rest_src
        assign a_rest_d = g_stage[k-1].g_fwd.a_rest_q[REST_W+SEG-1:SEG];
        assign b_rest_d = g_stage[k-1].g_fwd.b_rest_q[REST_W+SEG-1:SEG];
      end

      // Carry the not-yet-added operand segments along with the beat.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_rest_q <= '0;
          b_rest_q <= '0;
        end else if (!stall && v_in) begin
          a_rest_q <= a_rest_d;
          b_rest_q <= b_rest_d;
        end
      end
    end
  end

  assign s         = g_stage[LAST].sum_q;
  assign c_out     = g_stage[LAST].cy_q;
  assign out_valid = g_stage[LAST].vld_q;

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic ovf_d;
  logic zero_d;
  logic neg_d;
  logic ovf_q;
  logic zero_q;
  logic neg_q;
  logic msb_cin;

  // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign msb_cin = g_stage[LAST].seg_sum[SEG-1] ^ g_stage[LAST].a_seg[SEG-1]
                 ^ g_stage[LAST].b_seg[SEG-1];
  assign ovf_d   = msb_cin ^ g_stage[LAST].seg_sum[SEG];
  assign zero_d  = (g_stage[LAST].sum_d == '0);
  assign neg_d   = g_stage[LAST].seg_sum[SEG-1];

  // Flags load with the final stage so they stay aligned with s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (!stall && g_stage[LAST].v_in) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb_pipelined_adder_sub: directed and random checks of pipelined_adder_sub,
// a 32-bit/8-bit-segment instance and an 8-bit single-stage instance.
module tb_pipelined_adder_sub;

  localparam int WIDTH  = 32;
  localparam int SEG    = 8;
  localparam int STAGES = WIDTH / SEG;
  localparam int EW     = WIDTH + 4;
`ifdef PIPELINED_ADDER_FLAGS_EN
  localparam logic [EW-1:0] MASK = {EW{1'b1}};
`else
  localparam logic [EW-1:0] MASK = {3'b000, {(WIDTH+1){1'b1}}};
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic             in_valid, in_ready, out_valid, out_ready, sub, c_in, c_out;
  logic [WIDTH-1:0] a, b, s;
  logic             in_valid8, in_ready8, out_valid8, out_ready8, sub8, c_in8, c_out8;
  logic [7:0]       a8, b8, s8;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic ovf, zero, neg, ovf8, zero8, neg8;
`endif

  pipelined_adder_sub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .ovf(ovf), .zero(zero), .neg(neg)
`endif
  );

  pipelined_adder_sub #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .c_in(c_in8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .c_out(c_out8)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .ovf(ovf8), .zero(zero8), .neg(neg8)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [EW-1:0] exp_q[$];
  int acc_cyc_q[$];
  int pop_cyc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the plain WIDTH+1-bit arithmetic sum, with signed overflow
  // judged from operand and result signs. Packed as {neg, zero, ovf, c, s}.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                          input logic msub, input logic mcin);
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    logic             v;
    bp   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bp} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
    r    = full[WIDTH-1:0];
    v    = (ma[WIDTH-1] == bp[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
    return {r[WIDTH-1], (r == '0), v, full[WIDTH], r};
  endfunction

  // Monitor: record accepts, check every popped result against the model.
  always @(negedge clk) begin
    logic [EW-1:0] gw;
    logic [EW-1:0] e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        pop_cyc_q.push_back(cyc);
`ifdef PIPELINED_ADDER_FLAGS_EN
        gw = {neg, zero, ovf, c_out, s};
`else
        gw = {3'b000, c_out, s};
`endif
        checks++;
        assert (exp_q.size() != 0) passes++;
        else $error("FAIL out_unexpected: observed result %0h with nothing expected", gw);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 64'(gw), 64'(e & MASK));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, c_in));
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a    = $urandom;
    b    = $urandom;
    sub  = 1'($urandom_range(0, 1));
    c_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_one(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tsub, input logic tcin,
                          input logic [WIDTH-1:0] es, input logic ec, input string tag);
    int n;
    a = ta; b = tb; sub = tsub; c_in = tcin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(STAGES));
    check({tag, "_s"}, 64'(s), 64'(es));
    check({tag, "_c_out"}, 64'(c_out), 64'(ec));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, j, bi;
    logic acc;
    logic [WIDTH-1:0] hold_s;
    logic hold_c;

    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; c_in8 = 1'b0; out_ready8 = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_s", 64'(s), 64'(0));
    check("rst_c_out", 64'(c_out), 64'(0));
    check("rst_out_valid8", 64'(out_valid8), 64'(0));
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'(1));
    check("idle_out_valid", 64'(out_valid), 64'(0));

    // Single beats: values, carry and latency.
    send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, "add_seg_carry");
    send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, "add_wrap");
    send_one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, "add_cin");
    send_one(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
    send_one(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, "sub_no_borrow");
    send_one(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, "sub_ovf");

    // Streaming: 16 back-to-back random beats.
    acc_cyc_q.delete();
    pop_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check("stream_pops", 64'(pop_cyc_q.size()), 64'(16));
    check("stream_accepts", 64'(acc_cyc_q.size()), 64'(16));
    if (pop_cyc_q.size() == 16 && acc_cyc_q.size() == 16) begin
      check("stream_first_latency", 64'(pop_cyc_q[0] - acc_cyc_q[0]), 64'(STAGES));
      check("stream_accept_span", 64'(acc_cyc_q[15] - acc_cyc_q[0]), 64'(15));
      check("stream_pop_span", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'(15));
    end

    // Backpressure: out_ready low for 3 cycles mid-stream.
    bi = 0;
    j = 0;
    rand_beat();
    while (bi < 10 && j < 60) begin
      out_ready = !(j >= 5 && j < 8);
      in_valid = 1'b1;
      #1;
      if (j >= 5 && j < 8) begin
        check("bp_in_ready", 64'(in_ready), 64'(0));
        if (j == 5) begin
          hold_s = s;
          hold_c = c_out;
          check("bp_out_valid", 64'(out_valid), 64'(1));
        end else begin
          check("bp_hold_s", 64'(s), 64'(hold_s));
          check("bp_hold_c", 64'(c_out), 64'(hold_c));
          check("bp_hold_valid", 64'(out_valid), 64'(1));
        end
      end
      acc = in_ready;
      tick();
      j++;
      if (acc) begin
        bi++;
        rand_beat();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check("bp_drained", 64'(exp_q.size()), 64'(0));
    check("bp_idle_valid", 64'(out_valid), 64'(0));

    // Reset with 3 beats in flight, asserted between clock edges.
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_s", 64'(s), 64'(0));
    check("midrst_c_out", 64'(c_out), 64'(0));
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("postrst_out_valid", 64'(out_valid), 64'(0));
    send_one(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, "postrst");

    // Single-stage 8-bit instance: latency 1, full carry chain.
    check("w8_idle_valid", 64'(out_valid8), 64'(0));
    a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; c_in8 = 1'b1; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("w8_add_valid", 64'(out_valid8), 64'(1));
    check("w8_add_s", 64'(s8), 64'(8'h01));
    check("w8_add_c_out", 64'(c_out8), 64'(1));
`ifdef PIPELINED_ADDER_FLAGS_EN
    check("w8_add_ovf", 64'(ovf8), 64'(1));
    check("w8_add_neg", 64'(neg8), 64'(0));
    check("w8_add_zero", 64'(zero8), 64'(0));
`endif
    tick();
    check("w8_bubble_valid", 64'(out_valid8), 64'(0));
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; c_in8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("w8_sub_valid", 64'(out_valid8), 64'(1));
    check("w8_sub_s", 64'(s8), 64'(8'hF0));
    check("w8_sub_c_out", 64'(c_out8), 64'(0));
`ifdef PIPELINED_ADDER_FLAGS_EN
    check("w8_sub_neg", 64'(neg8), 64'(1));
    check("w8_sub_ovf", 64'(ovf8), 64'(0));
`endif
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
- Parametrised successor to the fixed 8-bit ripple adder: a segmented, pipelined adder/subtractor of WIDTH bits.
- Split into STAGES = WIDTH/SEG segments, with the carry registered between segments so the clock period covers only SEG-bit ripple logic.
- Valid/ready handshake on both sides, with backpressure stalling the whole pipe.
- Sits between operand registers and a result consumer in datapath and ALU experiments.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG, minimum 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept an operand beat this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- sub  input  1  0 = a+b+c_in, 1 = a-b (b inverted, carry-in forced to 1, c_in ignored)
- c_in  input  1  carry-in for add mode
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts the result this cycle
- s  output  WIDTH  sum or difference
- c_out  output  1  carry out of the MSB; in sub mode, 1 = no borrow

Behaviour:
- Reset: all stage valid bits, segment registers, carries, s, c_out and out_valid go to 0 immediately on reset high, independent of clk. in_ready = 1 once reset is low.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall, combinational. When stall = 1, every pipe register holds.
- Accept: an accept occurs on a clk edge with in_valid & in_ready.
- Stage 0 on accept:
  - Computes segment 0 = a[SEG-1:0] + b'[SEG-1:0] + cin0, where b' = sub ? ~b : b and cin0 = sub ? 1 : c_in.
  - Registers the segment-0 sum, its carry, and the remaining a and b' upper segments.
- Stage k (1..STAGES-1): adds segment k of the skewed operands plus the registered carry from stage k-1. Lower result segments already computed are delayed alongside, so all segments of one beat align.
- Latency: the result appears on s/c_out with out_valid = 1 exactly STAGES cycles after accept, when no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle when out_ready = 1. No bubbles are inserted; bubbles on the input (in_valid = 0) propagate as valid = 0 slots.
- Output hold: s, c_out and out_valid hold stable while out_valid & ~out_ready.
- Wrap-around: s is the result mod 2^WIDTH. c_out is the true carry of the WIDTH-bit add of a, b' and cin0.
- Simultaneous events:
  - Output pop and input accept in the same cycle: both occur, since stall = 0 whenever out_ready = 1.
  - out_ready = 0 while out_valid = 0: does not stall; bubbles are overwritten.
- Reset mid-operation: all in-flight beats are discarded and no partial result is presented.
- STAGES = 1: degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDER_FLAGS_EN.
- When defined, adds three output ports, registered and aligned with s, reset to 0, and held under stall:
  - ovf: signed overflow, i.e. the carry into the MSB XOR the carry out of the MSB.
  - zero: s == 0.
  - neg: s[WIDTH-1].
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- WIDTH=32, SEG=8, add: a=0x000000FF, b=0x00000001, c_in=0 -> after 4 cycles s=0x00000100, c_out=0; a=0xFFFFFFFF, b=1 -> s=0, c_out=1.
- Sub: a=5, b=7, sub=1 -> s=0xFFFFFFFE, c_out=0; a=7, b=5 -> s=2, c_out=1. With flags: a=0x80000000, b=1 -> ovf=1, neg=0.
- Streaming: 16 back-to-back random beats with out_ready=1 -> 16 results in order on consecutive cycles, first one 4 cycles after the first accept, all matching the reference model.
- Backpressure: out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, s/out_valid held, no beat lost or duplicated.
- Reset mid-stream: assert reset with 3 beats in flight, asynchronously between edges -> out_valid=0 and s=0 immediately; after release the next beat emerges with latency 4.
- SEG=WIDTH=8 build: carry chain a=0x80, b=0x80, c_in=1 -> s=0x01, c_out=1, latency 1.
